adc_header_parser: RTL and testbench

ADC_HEADER_PARSER -- requirements
Module: adc_header_parser

---
 rtl/adc_header_parser_pkg.sv | 22 ++
 rtl/adc_header_parser_sat_counter16.sv | 35 +++
 rtl/adc_header_parser.sv | 123 ++++++++++++
 tb/tb_adc_header_parser.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_header_parser_pkg.sv
// Shared types and constants for the ADC link header parser.
// Holds the parser state encoding, marker defaults and field widths.
package adc_header_parser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPILL,
        ST_EVT,
        ST_PAYLOAD,
        ST_TRAILER
    } state_e;

    localparam logic [15:0] SOP_DEFAULT = 16'hF0F0;
    localparam logic [15:0] EOP_DEFAULT = 16'h0F0F;

    localparam int SPILL_W = 10;
    localparam int EVT_W   = 16;
    localparam int DATA_W  = 16;
    localparam int PCNT_W  = 8;
    localparam int CNT_W   = 16;

endpackage

// File: rtl/adc_header_parser_sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
// Reset and clear both return it to zero; reset wins.
module sat_counter16
    import adc_header_parser_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/adc_header_parser.sv
// Frames the ADC link stream: SOP, spill, event, payload, EOP.
// Payload is passed through; header fields and error counts are kept.
module adc_header_parser
    import adc_header_parser_pkg::*;
#(
    parameter int          PAYLOAD_LEN = 64,
    parameter logic [15:0] SOP_WORD    = SOP_DEFAULT,
    parameter logic [15:0] EOP_WORD    = EOP_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               live_rising,
    input  logic [DATA_W-1:0]  din,
    input  logic               din_valid,
    output logic [SPILL_W-1:0] pkg_spillno,
    output logic [EVT_W-1:0]   pkg_evtno,
    output logic               get_package,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid,
    output logic               frame_err,
    output logic [CNT_W-1:0]   frame_err_cnt,
    output logic [CNT_W-1:0]   drop_cnt
);

    localparam logic [PCNT_W-1:0] LAST_IDX =
        PCNT_W'(PAYLOAD_LEN - 1);

    state_e             state_q;
    logic [PCNT_W-1:0]  pcnt_q;
    logic [SPILL_W-1:0] spill_q;
    logic [EVT_W-1:0]   evt_q;
    logic [DATA_W-1:0]  dout_q;
    logic               dout_valid_q;
    logic               get_pkg_q;
    logic               frame_err_q;

    logic               accept_d;
    logic               drop_inc_d;
    logic               ferr_inc_d;

    // live_rising swallows a coincident word, so it never counts
    assign accept_d   = din_valid && !live_rising;
    assign drop_inc_d = accept_d && (state_q == ST_IDLE)
                        && (din != SOP_WORD);
    assign ferr_inc_d = accept_d && (state_q == ST_TRAILER)
                        && (din != EOP_WORD);

    always_ff @(posedge clk) begin
        get_pkg_q    <= 1'b0;
        frame_err_q  <= 1'b0;
        dout_valid_q <= 1'b0;
        if (rst) begin
            state_q <= ST_IDLE;
            pcnt_q  <= '0;
            spill_q <= '0;
            evt_q   <= '0;
            dout_q  <= '0;
        end else if (live_rising) begin
            state_q <= ST_IDLE;
            pcnt_q  <= '0;
        end else if (din_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (din == SOP_WORD) begin
                        state_q <= ST_SPILL;
                    end
                end
                ST_SPILL: begin
                    spill_q <= din[SPILL_W-1:0];
                    state_q <= ST_EVT;
                end
                ST_EVT: begin
                    evt_q   <= din;
                    pcnt_q  <= '0;
                    state_q <= ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    dout_q       <= din;
                    dout_valid_q <= 1'b1;
                    pcnt_q       <= pcnt_q + 1'b1;
                    if (pcnt_q == LAST_IDX) begin
                        state_q <= ST_TRAILER;
                    end
                end
                ST_TRAILER: begin
                    if (din == EOP_WORD) begin
                        get_pkg_q <= 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter16 u_ferr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (live_rising),
        .inc_i (ferr_inc_d),
        .cnt_o (frame_err_cnt)
    );

    sat_counter16 u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (live_rising),
        .inc_i (drop_inc_d),
        .cnt_o (drop_cnt)
    );

    assign pkg_spillno = spill_q;
    assign pkg_evtno   = evt_q;
    assign get_package = get_pkg_q;
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_adc_header_parser.sv
// Directed bench for adc_header_parser with a 4-word payload.
// A monitor logs output beats; each scenario task checks its own results.
module tb_adc_header_parser;

    logic        clk;
    logic        rst;
    logic        live_rising;
    logic [15:0] din;
    logic        din_valid;
    logic [9:0]  pkg_spillno;
    logic [15:0] pkg_evtno;
    logic        get_package;
    logic [15:0] dout;
    logic        dout_valid;
    logic        frame_err;
    logic [15:0] frame_err_cnt;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] dq[$];
    int          gp_n;
    int          fe_n;
    logic [9:0]  gp_spill;
    logic [15:0] gp_evt;

    adc_header_parser #(
        .PAYLOAD_LEN (4),
        .SOP_WORD    (16'hF0F0),
        .EOP_WORD    (16'h0F0F)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .live_rising   (live_rising),
        .din           (din),
        .din_valid     (din_valid),
        .pkg_spillno   (pkg_spillno),
        .pkg_evtno     (pkg_evtno),
        .get_package   (get_package),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .frame_err     (frame_err),
        .frame_err_cnt (frame_err_cnt),
        .drop_cnt      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (dout_valid) dq.push_back(dout);
        if (get_package) begin
            gp_n++;
            gp_spill = pkg_spillno;
            gp_evt   = pkg_evtno;
        end
        if (frame_err) fe_n++;
    end

    task automatic clr_log();
        dq.delete();
        gp_n = 0;
        fe_n = 0;
        gp_spill = 'x;
        gp_evt = 'x;
    endtask

    task automatic word(input logic [15:0] w, input bit gap);
        @(negedge clk);
        din = w;
        din_valid = 1'b1;
        if (gap) begin
            @(negedge clk);
            din_valid = 1'b0;
            din = 16'hDEAD;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pkg(
        input logic [9:0]  sp,
        input logic [15:0] ev,
        input logic [15:0] p0, p1, p2, p3,
        input logic [15:0] trl,
        input bit          gap
    );
        word(16'hF0F0, gap);
        word({6'b0, sp}, gap);
        word(ev, gap);
        word(p0, gap);
        word(p1, gap);
        word(p2, gap);
        word(p3, gap);
        word(trl, gap);
        idle(3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        live_rising = 1'b0;
        din = 16'h0;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({pkg_spillno, pkg_evtno, dout} !== 42'h0) begin
            n_bad++;
            $display("FAIL reset_fields: got %h/%h/%h want 0",
                pkg_spillno, pkg_evtno, dout);
        end
        n_cmp++;
        if ({get_package, frame_err, dout_valid} !== 3'b0) begin
            n_bad++;
            $display("FAIL reset_pulses: got %b%b%b want 000",
                get_package, frame_err, dout_valid);
        end
        n_cmp++;
        if ({frame_err_cnt, drop_cnt} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_cnts: got %h/%h want 0",
                frame_err_cnt, drop_cnt);
        end
        rst = 1'b0;
        clr_log();
    endtask

    task automatic test_clean(input bit gap);
        logic [15:0] exp[4];
        logic [15:0] got;
        exp = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        clr_log();
        send_pkg(10'h155, 16'h0001, exp[0], exp[1],
                 exp[2], exp[3], 16'h0F0F, gap);
        n_cmp++;
        if (dq.size() !== 4) begin
            n_bad++;
            $display("FAIL clean%0d_beats: got %0d want 4",
                gap, dq.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < dq.size()) ? dq[i] : 16'hxxxx;
            n_cmp++;
            if (got !== exp[i]) begin
                n_bad++;
                $display("FAIL clean%0d_dout%0d: got %h want %h",
                    gap, i, got, exp[i]);
            end
        end
        n_cmp++;
        if (gp_n !== 1) begin
            n_bad++;
            $display("FAIL clean%0d_gp: got %0d want 1", gap, gp_n);
        end
        n_cmp++;
        if (gp_spill !== 10'h155 || gp_evt !== 16'h0001) begin
            n_bad++;
            $display("FAIL clean%0d_hdr: got %h/%h want 155/0001",
                gap, gp_spill, gp_evt);
        end
        n_cmp++;
        if (fe_n !== 0) begin
            n_bad++;
            $display("FAIL clean%0d_fe: got %0d want 0", gap, fe_n);
        end
    endtask

    task automatic test_bad_trailer();
        clr_log();
        send_pkg(10'h0AA, 16'h0005, 16'h1, 16'h2,
                 16'h3, 16'h4, 16'h1234, 1'b0);
        n_cmp++;
        if (fe_n !== 1 || frame_err_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL badtrl_fe: got %0d/%h want 1/0001",
                fe_n, frame_err_cnt);
        end
        n_cmp++;
        if (gp_n !== 0) begin
            n_bad++;
            $display("FAIL badtrl_gp: got %0d want 0", gp_n);
        end
        clr_log();
        send_pkg(10'h2AA, 16'h0006, 16'h5, 16'h6,
                 16'h7, 16'h8, 16'h0F0F, 1'b0);
        n_cmp++;
        if (gp_n !== 1 || gp_spill !== 10'h2AA
            || gp_evt !== 16'h0006) begin
            n_bad++;
            $display("FAIL badtrl_next: got %0d %h/%h want 1 2aa/0006",
                gp_n, gp_spill, gp_evt);
        end
        n_cmp++;
        if (frame_err_cnt !== 16'd1 || drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL badtrl_cnts: got %h/%h want 0001/0000",
                frame_err_cnt, drop_cnt);
        end
    endtask

    task automatic test_junk();
        clr_log();
        word(16'h1111, 1'b0);
        word(16'h0F0F, 1'b0);
        word(16'h2222, 1'b0);
        idle(1);
        n_cmp++;
        if (drop_cnt !== 16'd3) begin
            n_bad++;
            $display("FAIL junk_drop: got %h want 0003", drop_cnt);
        end
        send_pkg(10'h3C3, 16'h00AB, 16'hF0F0, 16'h0F0F,
                 16'hF0F0, 16'h5555, 16'h0F0F, 1'b0);
        n_cmp++;
        if (dq.size() !== 4 || dq[0] !== 16'hF0F0
            || dq[1] !== 16'h0F0F || dq[3] !== 16'h5555) begin
            n_bad++;
            $display("FAIL junk_data: got %0d beats, d0=%h want F0F0",
                dq.size(), (dq.size() > 0) ? dq[0] : 16'hxxxx);
        end
        n_cmp++;
        if (gp_n !== 1 || gp_evt !== 16'h00AB
            || gp_spill !== 10'h3C3) begin
            n_bad++;
            $display("FAIL junk_gp: got %0d %h/%h want 1 3c3/00ab",
                gp_n, gp_spill, gp_evt);
        end
        n_cmp++;
        if (drop_cnt !== 16'd3) begin
            n_bad++;
            $display("FAIL junk_hold: got %h want 0003", drop_cnt);
        end
    endtask

    task automatic test_live();
        clr_log();
        word(16'hF0F0, 1'b0);
        word(16'h00AB, 1'b0);
        word(16'h0777, 1'b0);
        word(16'hC001, 1'b0);
        word(16'hC002, 1'b0);
        @(negedge clk);
        din_valid = 1'b0;
        live_rising = 1'b1;
        @(negedge clk);
        live_rising = 1'b0;
        idle(3);
        n_cmp++;
        if (frame_err_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL live_cnts: got %h/%h want 0/0",
                frame_err_cnt, drop_cnt);
        end
        n_cmp++;
        if (gp_n !== 0 || dq.size() !== 2) begin
            n_bad++;
            $display("FAIL live_abort: got gp=%0d beats=%0d want 0/2",
                gp_n, dq.size());
        end
        n_cmp++;
        if (pkg_spillno !== 10'h0AB || pkg_evtno !== 16'h0777) begin
            n_bad++;
            $display("FAIL live_hdr: got %h/%h want 0ab/0777",
                pkg_spillno, pkg_evtno);
        end
        @(negedge clk);
        din = 16'hF0F0;
        din_valid = 1'b1;
        live_rising = 1'b1;
        @(negedge clk);
        live_rising = 1'b0;
        din_valid = 1'b0;
        clr_log();
        send_pkg(10'h001, 16'h0002, 16'h11, 16'h22,
                 16'h33, 16'h44, 16'h0F0F, 1'b0);
        n_cmp++;
        if (gp_n !== 1 || gp_evt !== 16'h0002
            || gp_spill !== 10'h001) begin
            n_bad++;
            $display("FAIL live_next: got %0d %h/%h want 1 001/0002",
                gp_n, gp_spill, gp_evt);
        end
        n_cmp++;
        if (drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL live_coinc: got %h want 0000", drop_cnt);
        end
    endtask

    task automatic test_rst_mid();
        clr_log();
        word(16'hF0F0, 1'b0);
        word(16'h03FF, 1'b0);
        word(16'hBEEF, 1'b0);
        word(16'h9999, 1'b0);
        @(negedge clk);
        din_valid = 1'b0;
        rst = 1'b1;
        live_rising = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        live_rising = 1'b0;
        idle(3);
        n_cmp++;
        if (gp_n !== 0 || fe_n !== 0) begin
            n_bad++;
            $display("FAIL rstmid_pulses: got gp=%0d fe=%0d want 0/0",
                gp_n, fe_n);
        end
        n_cmp++;
        if (pkg_spillno !== 10'h0 || pkg_evtno !== 16'h0) begin
            n_bad++;
            $display("FAIL rstmid_hdr: got %h/%h want 0/0",
                pkg_spillno, pkg_evtno);
        end
        clr_log();
        send_pkg(10'h007, 16'h0003, 16'h1, 16'h2,
                 16'h3, 16'h4, 16'h0F0F, 1'b0);
        n_cmp++;
        if (gp_n !== 1 || gp_evt !== 16'h0003) begin
            n_bad++;
            $display("FAIL rstmid_next: got %0d/%h want 1/0003",
                gp_n, gp_evt);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 65534; i++) begin
            @(negedge clk);
            din = 16'h1234;
            din_valid = 1'b1;
        end
        idle(1);
        n_cmp++;
        if (drop_cnt !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL sat_pre: got %h want fffe", drop_cnt);
        end
        word(16'h0001, 1'b0);
        word(16'h0002, 1'b0);
        word(16'h0003, 1'b0);
        idle(1);
        n_cmp++;
        if (drop_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_hold: got %h want ffff", drop_cnt);
        end
        n_cmp++;
        if (frame_err_cnt !== 16'h0) begin
            n_bad++;
            $display("FAIL sat_ferr: got %h want 0000", frame_err_cnt);
        end
    endtask

    initial begin
        clr_log();
        test_reset();
        test_clean(1'b0);
        test_clean(1'b1);
        test_bad_trailer();
        test_junk();
        test_live();
        test_rst_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
            n_cmp, n_bad);
        $finish;
    end

endmodule
